// File: rtl/capture_buffer_arbiter_if.sv
// capture_buffer_arbiter_if: capture input, host readout, status and RAM port signals
// of capture_buffer_arbiter; master is the environment side, slave the arbiter.
interface capture_buffer_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 8,
   parameter int FW = 8
);
   logic [DW-1:0] dbus;
   logic          wren;
   logic          rd_req;
   logic          rd_ack;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          ovf_clr;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [AW:0]   fill;
   logic          empty;
   logic          full;
   logic          overflow;
   logic [FW-1:0] frame_cnt;
   modport master (
      output dbus, wren, rd_req, ovf_clr, mem_rdata,
      input  rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata,
             fill, empty, full, overflow, frame_cnt
   );
   modport slave (
      input  dbus, wren, rd_req, ovf_clr, mem_rdata,
      output rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata,
             fill, empty, full, overflow, frame_cnt
   );
endinterface

// File: rtl/capture_buffer_arbiter.sv
// capture_buffer_arbiter: shares one single-port capture RAM between the capture writer and a
// FIFO-order host reader. Define CAPTURE_WRAP_EN to overwrite the oldest word when FULL.
module capture_buffer_arbiter #(
   parameter int DW = 16,
   parameter int AW = 8,
   parameter int FW = 8
) (
   input logic clk,
   input logic rst_n,
   capture_buffer_arbiter_if.slave bus
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   typedef enum logic [1:0] {IDLE, CAPT, RDWT} state_t;
   state_t        state, state_nx;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fill;
   logic [DW-1:0] rd_hold;
   logic [FW-1:0] frame_cnt;
   logic          full, wr_go, rd_go, frame_end, rd_valid, overflow;
   assign full     = fill == DEPTH;
   assign rd_valid = state == RDWT;
`ifdef CAPTURE_WRAP_EN
   assign wr_go = bus.wren;
`else
   assign wr_go = bus.wren & ~full;
`endif
   // Writes take the RAM in every state; a read is only issued from IDLE on a write-free cycle.
   always_comb begin
      state_nx  = IDLE;
      rd_go     = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            rd_go    = ~bus.wren & bus.rd_req & (fill != '0);
            state_nx = bus.wren ? CAPT : rd_go ? RDWT : IDLE;
         end
         CAPT: begin
            frame_end = ~bus.wren;
            state_nx  = bus.wren ? CAPT : IDLE;
         end
         default: state_nx = bus.wren ? CAPT : IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         overflow  <= 1'b0;
         frame_cnt <= '0;
         rd_hold   <= '0;
      end else begin
         state <= state_nx;
         if (wr_go) wr_ptr <= wr_ptr + 1'b1;
         // An overwrite at FULL discards the oldest word, so the read pointer follows.
         if (rd_go || (wr_go && full)) rd_ptr <= rd_ptr + 1'b1;
         if (wr_go && !full) fill <= fill + 1'b1;
         else if (rd_go) fill <= fill - 1'b1;
         overflow <= (bus.wren & full) | (overflow & ~bus.ovf_clr);
         if (frame_end) frame_cnt <= frame_cnt + 1'b1;
         if (rd_valid) rd_hold <= bus.mem_rdata;
      end
   end
   // Combinational strobes are gated so nothing reaches the RAM or host while reset is held.
   assign bus.mem_en    = rst_n & (wr_go | rd_go);
   assign bus.mem_we    = rst_n & wr_go;
   assign bus.mem_addr  = bus.wren ? wr_ptr : rd_ptr;
   assign bus.mem_wdata = bus.dbus;
   assign bus.rd_ack    = rst_n & rd_go;
   assign bus.rd_valid  = rd_valid;
   assign bus.rd_data   = rd_valid ? bus.mem_rdata : rd_hold;
   assign bus.fill      = fill;
   assign bus.empty     = fill == '0;
   assign bus.full      = full;
   assign bus.overflow  = overflow;
   assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_capture_buffer_arbiter.sv
// tb_capture_buffer_arbiter: queue-based reference model compared every cycle, plus directed
// literal checks of reset, capture, readout, arbitration and FULL behaviour.
module tb_capture_buffer_arbiter;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int FW = 8;
   localparam int DEPTH = 1 << AW;
`ifdef CAPTURE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   capture_buffer_arbiter_if #(.DW(DW), .AW(AW), .FW(FW)) bus ();
   capture_buffer_arbiter #(.DW(DW), .AW(AW), .FW(FW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk)
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else bus.mem_rdata <= ram[bus.mem_addr];
      end

   int n_cmp = 0;
   int n_bad = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stored words as a queue, total words written, and two history bits
   // (previous cycle captured / previous cycle was a read acceptance).
   logic [DW-1:0] q [$];
   logic [DW-1:0] pend;
   int  wcnt = 0, m_frames = 0;
   bit  m_ovf = 0, prev_wren = 0, prev_ack = 0, full_now, wr, rd;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_mem_en", 32'(bus.mem_en), 0);
         chk("rst_mem_we", 32'(bus.mem_we), 0);
         chk("rst_rd_ack", 32'(bus.rd_ack), 0);
         chk("rst_rd_valid", 32'(bus.rd_valid), 0);
         chk("rst_rd_data", 32'(bus.rd_data), 0);
         chk("rst_fill", 32'(bus.fill), 0);
         chk("rst_empty", 32'(bus.empty), 1);
         chk("rst_overflow", 32'(bus.overflow), 0);
         chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
         q.delete();
         wcnt = 0; m_frames = 0; m_ovf = 0; prev_wren = 0; prev_ack = 0;
      end else begin
         full_now = q.size() == DEPTH;
         wr = bus.wren && (!full_now || WRAP);
         rd = !bus.wren && bus.rd_req && q.size() != 0 && !prev_wren && !prev_ack;
         chk("mem_en", 32'(bus.mem_en), 32'(wr || rd));
         chk("mem_we", 32'(bus.mem_we), 32'(wr));
         if (wr) chk("wr_addr", 32'(bus.mem_addr), 32'(wcnt % DEPTH));
         if (wr) chk("wdata", 32'(bus.mem_wdata), 32'(bus.dbus));
         if (rd) chk("rd_addr", 32'(bus.mem_addr), 32'((wcnt - q.size()) % DEPTH));
         chk("rd_ack", 32'(bus.rd_ack), 32'(rd));
         chk("rd_valid", 32'(bus.rd_valid), 32'(prev_ack));
         if (prev_ack) chk("rd_data", 32'(bus.rd_data), 32'(pend));
         chk("fill", 32'(bus.fill), 32'(q.size()));
         chk("empty", 32'(bus.empty), 32'(q.size() == 0));
         chk("full", 32'(bus.full), 32'(full_now));
         chk("overflow", 32'(bus.overflow), 32'(m_ovf));
         chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames % (1 << FW)));
         if (rd) pend = q.pop_front();
         if (wr) begin
            if (full_now) void'(q.pop_front());
            q.push_back(bus.dbus);
            wcnt++;
         end
         m_ovf = (bus.wren && full_now) || (m_ovf && !bus.ovf_clr);
         if (prev_wren && !bus.wren) m_frames++;
         prev_wren = bus.wren;
         prev_ack = rd;
      end
   end

   logic          s_ack, s_we, s_valid;
   logic [DW-1:0] s_data;
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      bus.wren = w; bus.dbus = d; bus.rd_req = r; bus.ovf_clr = c;
      @(negedge clk);
      s_ack = bus.rd_ack; s_we = bus.mem_we; s_valid = bus.rd_valid; s_data = bus.rd_data;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   logic [DW-1:0] got [$];
   int  acks;
   bit  w;
   initial begin
      bus.wren = 0; bus.dbus = '0; bus.rd_req = 0; bus.ovf_clr = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // Reset in the middle of a capture window, with WREN still high.
      repeat (3) step(1, 16'hAAAA, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("t1_fill", 32'(bus.fill), 0);
      chk("t1_empty", 32'(bus.empty), 1);
      chk("t1_mem_en", 32'(bus.mem_en), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      // Reset during a read acceptance: the in-flight read must never produce RD_VALID.
      step(1, 16'h0077, 0, 0);
      step(0, 16'h0000, 0, 0);
      bus.rd_req = 1'b1;
      #2 chk("t1_ack_before_rst", 32'(bus.rd_ack), 1);
      pulse_reset();
      step(0, 16'h0000, 0, 0);
      chk("t1_no_valid", 32'(s_valid), 0);
      // Four-word capture window.
      for (int i = 1; i <= 4; i++) step(1, 16'(16'h1111 * i), 0, 0);
      step(0, 16'h0000, 0, 0);
      chk("t2_fill", 32'(bus.fill), 4);
      chk("t2_frame_cnt", 32'(bus.frame_cnt), 1);
      for (int i = 0; i < 4; i++) chk("t2_ram", 32'(ram[i]), 32'(16'h1111 * (i + 1)));
      // Drain with RD_REQ held.
      acks = 0;
      for (int i = 0; i < 9; i++) begin
         step(0, 16'h0000, 1, 0);
         if (s_ack) acks++;
         if (s_valid) got.push_back(s_data);
      end
      chk("t3_acks", 32'(acks), 4);
      chk("t3_count", 32'(got.size()), 4);
      for (int i = 0; i < got.size(); i++) chk("t3_data", 32'(got[i]), 32'(16'h1111 * (i + 1)));
      chk("t3_empty", 32'(bus.empty), 1);
      // Write and read request together: the write wins.
      step(1, 16'h5555, 1, 0);
      chk("t4_ack_blocked", 32'(s_ack), 0);
      chk("t4_we", 32'(s_we), 1);
      step(0, 16'h0000, 1, 0);
      chk("t4_ack_capt", 32'(s_ack), 0);
      step(0, 16'h0000, 1, 0);
      chk("t4_ack_idle", 32'(s_ack), 1);
      step(0, 16'h0000, 0, 0);
      chk("t4_valid", 32'(s_valid), 1);
      chk("t4_data", 32'(s_data), 32'h5555);
      // Fill to FULL, then one more write.
      for (int i = 0; i < DEPTH; i++) step(1, 16'(16'hA000 + i), 0, 0);
      step(1, 16'hA0FF, 0, 0);
      step(0, 16'h0000, 0, 0);
      chk("t5_overflow", 32'(bus.overflow), 1);
      chk("t5_fill", 32'(bus.fill), 16);
      step(0, 16'h0000, 1, 0);
      chk("t5_ack", 32'(s_ack), 1);
      step(0, 16'h0000, 0, 0);
      chk("t5_valid", 32'(s_valid), 1);
      chk("t5_first", 32'(s_data), WRAP ? 32'hA001 : 32'hA000);
      // OVERFLOW clear alone, then clear colliding with a write at FULL.
      step(0, 16'h0000, 0, 1);
      chk("t6_cleared", 32'(bus.overflow), 0);
      step(1, 16'hC000, 0, 0);
      chk("t6_full", 32'(bus.full), 1);
      step(1, 16'hC001, 0, 1);
      chk("t6_set_wins", 32'(bus.overflow), 1);
      step(0, 16'h0000, 0, 0);
      // Randomized traffic: write-heavy, then read-heavy, with one reset in between.
      w = 0;
      for (int i = 0; i < 1600; i++) begin
         if (i == 900) pulse_reset();
         if ($urandom_range(0, 99) < (i < 800 ? 30 : 12)) w = ~w;
         if (i >= 800 && w && $urandom_range(0, 3) == 0) w = 0;
         step(w, 16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      end
      for (int i = 0; i < 40; i++) step(0, 16'h0000, 1, 0);
      chk("end_empty", 32'(bus.empty), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
